ulpi_link_ctrl: RTL and testbench
=================================

Name: ulpi_link_ctrl

Overview:
- Parametrised ULPI link-side controller; next generation of the fixed 66-byte USB state machine.
- Owns the ULPI bus (dir/nxt/stp/data) in the ULPI clock domain:
  - decodes RX CMD and RX data bytes;
  - transmits variable-length packets with TX CMD (PID) header and nxt handshake;
  - handles bus turnaround and PHY-initiated TX abort.
- Sits between the ULPI pins and the packet/FIFO layer.

Parameters:
- MAX_TX_BYTES, 64: payload buffer depth in bytes (1..255).
- LEN_W, $clog2(MAX_TX_BYTES+1): width of tx_len.

Ports:
- clk  in  1  ULPI 60 MHz clock; all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- ulpi_dir  in  1  PHY owns bus when 1.
- ulpi_nxt  in  1  PHY throttle/strobe.
- ulpi_data_in  in  8  bus data from PHY.
- ulpi_data_out  out  8  bus data to PHY; 0x00 when idle.
- ulpi_stp  out  1  end-of-packet strobe to PHY.
- tx_start  in  1  one-cycle request; samples tx_pid, tx_len, tx_payload.
- tx_pid  in  4  PID nibble.
- tx_len  in  LEN_W  payload byte count; 0 = PID-only packet.
- tx_payload  in  8*MAX_TX_BYTES  byte 0 in bits [7:0], sent first.
- tx_busy  out  1  high from accepted tx_start until done/abort.
- tx_done  out  1  one-cycle pulse on the stp cycle.
- tx_abort  out  1  one-cycle pulse when dir preempts a TX.
- rx_byte_valid  out  1  one-cycle pulse per received data byte.
- rx_byte  out  8  received data byte.
- rx_cmd_valid  out  1  one-cycle pulse per RX CMD.
- rx_cmd  out  8  last RX CMD byte.
- rx_active  out  1  RxActive from last RX CMD.

Behaviour:
- Reset (async, n_rst=0):
  - state IDLE; ulpi_data_out=0x00; ulpi_stp=0;
  - tx_busy, tx_done, tx_abort, rx_byte_valid, rx_cmd_valid, rx_active = 0;
  - rx_byte=0x00; rx_cmd=0x00.
  - Reset mid-transfer discards all state; no stp is emitted.
- All outputs are registered. Status pulses appear the cycle after the sampling edge.
- States:
  - IDLE
  - TX_CMD
  - TX_DATA
  - TX_STP
  - TURN_IN
  - RX
  - TURN_OUT
- IDLE:
  - dir=1 -> TURN_IN; takes priority over tx_start in the same cycle, and that tx_start is dropped.
  - tx_start with dir=0 -> latch pid/len/payload; tx_busy=1; ulpi_data_out = {4'b0100, pid}; -> TX_CMD.
- TX_CMD:
  - Hold the TX CMD byte until nxt=1.
  - On nxt with len=0 -> TX_STP.
  - On nxt with len>0 -> drive payload byte 0 -> TX_DATA.
- TX_DATA:
  - Hold the current byte while nxt=0.
  - On nxt, advance the index.
  - After byte len-1 is accepted -> TX_STP.
- TX_STP:
  - One cycle: ulpi_stp=1, ulpi_data_out=0x00, tx_done=1, tx_busy deasserts.
  - Then -> IDLE.
- Abort: dir=1 in TX_CMD or TX_DATA ->
  - ulpi_data_out=0x00 immediately (next edge); no stp;
  - tx_abort=1 pulse; tx_busy=0;
  - -> TURN_IN. No retry.
- TURN_IN:
  - One cycle; ulpi_data_in ignored.
  - dir still 1 -> RX; dir=0 -> TURN_OUT.
- RX, sampled each cycle with dir=1:
  - nxt=0: rx_cmd <= data_in; rx_cmd_valid pulse; rx_active <= (data_in[5:4]==2'b01).
  - nxt=1: rx_byte <= data_in; rx_byte_valid pulse.
  - dir=0 -> TURN_OUT; the data on that edge is ignored.
- TURN_OUT:
  - One cycle; rx_active cleared.
  - -> IDLE; tx_start is accepted only in IDLE.
- tx_start while tx_busy: ignored.
- tx_len > MAX_TX_BYTES: clamped to MAX_TX_BYTES.
- The byte index wraps never; it is compared against the latched len.

Decomposition:
- Package ulpi_pkg holds:
  - state enum ulpi_state_t;
  - TXCMD_PREFIX = 4'b0100;
  - RXEVT_ACTIVE = 2'b01, RXEVT_ERROR = 2'b11;
  - RX CMD field positions.
- One natural sub-module, ulpi_tx_shifter: latches payload and len, and provides the current byte and a last flag on advance.

Test Plan:
- Reset: n_rst=0 mid-TX -> next edge ulpi_data_out=0x00, stp=0, tx_busy=0, all pulses 0.
- RX CMD only: dir 0->1, turnaround, data 0x1F with nxt=0 -> rx_cmd_valid pulse, rx_cmd=0x1F, rx_active=1, no rx_byte_valid.
- RX data burst: after RX CMD 0x10, nxt=1 with bytes 0xAA, 0x55, 0xFF -> three rx_byte_valid pulses in order; dir drop -> rx_active=0 after TURN_OUT.
- TX 3 bytes: pid=0x3, payload BB,AA,CC; nxt asserted 2 cycles late, then toggled -> bus 0x43 held, then BB,AA,CC each held until nxt; stp=1 with data 0x00 one cycle; tx_done pulse.
- PID-only TX: tx_len=0, pid=0x2 -> 0x42 until nxt, then stp cycle, tx_done; no payload bytes.
- Abort: dir=1 while byte 1 of 4 is pending -> data_out=0x00, no stp, tx_abort pulse, RX path then receives RX CMD 0x10 correctly.

Source files
------------

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared state encoding, ULPI command constants and small helpers
// for the ULPI link-side controller.
package ulpi_pkg;

  // Link controller states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_CMD   = 3'd1,
    ST_TX_DATA  = 3'd2,
    ST_TX_STP   = 3'd3,
    ST_TURN_IN  = 3'd4,
    ST_RX       = 3'd5,
    ST_TURN_OUT = 3'd6
  } ulpi_state_t;

  // Upper nibble of a TX CMD byte carrying a PID (transmit command).
  localparam logic [3:0] TXCMD_PREFIX = 4'b0100;

  // RxEvent field encodings inside an RX CMD byte.
  localparam logic [1:0] RXEVT_ACTIVE = 2'b01;
  localparam logic [1:0] RXEVT_ERROR  = 2'b11;

  // RX CMD field positions.
  localparam int RXCMD_LINESTATE_LSB = 0;
  localparam int RXCMD_LINESTATE_MSB = 1;
  localparam int RXCMD_VBUS_LSB      = 2;
  localparam int RXCMD_VBUS_MSB      = 3;
  localparam int RXCMD_RXEVT_LSB     = 4;
  localparam int RXCMD_RXEVT_MSB     = 5;

  // Build the TX CMD byte that opens a packet.
  function automatic logic [7:0] txcmd_byte(input logic [3:0] pid);
    return {TXCMD_PREFIX, pid};
  endfunction

  // True when the RxEvent field of an RX CMD reports RxActive.
  function automatic logic rxcmd_is_active(input logic [7:0] cmd);
    return cmd[RXCMD_RXEVT_MSB:RXCMD_RXEVT_LSB] == RXEVT_ACTIVE;
  endfunction

endpackage

// File: rtl/ulpi_tx_shifter.sv
// ulpi_tx_shifter: holds one outgoing packet payload. The payload is loaded
// into a byte shift register; the current byte is always in the low byte and
// each accepted byte shifts the next one down. A separate index, compared to
// the clamped latched length, flags the final byte.
module ulpi_tx_shifter #(
  parameter int MAX_TX_BYTES = 64,
  parameter int LEN_W        = $clog2(MAX_TX_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_load,
  input  logic [LEN_W-1:0]          i_len,
  input  logic [8*MAX_TX_BYTES-1:0] i_payload,
  input  logic                      i_advance,
  output logic [7:0]                o_cur_byte,
  output logic [7:0]                o_next_byte,
  output logic                      o_last,
  output logic                      o_empty
);

  logic [8*MAX_TX_BYTES-1:0] r_sh;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_idx;
  logic [8*MAX_TX_BYTES-1:0] w_shifted;

  // Requests longer than the buffer are sent as a full buffer.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_TX_BYTES)) begin
      return LEN_W'(MAX_TX_BYTES);
    end
    return len;
  endfunction

  assign w_shifted   = r_sh >> 8;
  assign o_cur_byte  = r_sh[7:0];
  assign o_next_byte = w_shifted[7:0];
  assign o_last      = (r_idx + LEN_W'(1)) == r_len;
  assign o_empty     = (r_len == '0);

  // Payload storage: loaded on accept, shifted down one byte per handshake.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_sh <= i_payload;
    end else if (i_advance) begin
      r_sh <= w_shifted;
    end
  end

  // Length and byte index bookkeeping; the index only counts up to len-1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_len <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_len <= clamp_len(i_len);
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= r_idx + LEN_W'(1);
    end
  end

endmodule

// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: ULPI link-side controller. Owns the ULPI bus in the ULPI
// clock domain: sends TX CMD + payload packets with nxt handshaking, decodes
// RX CMD and RX data bytes, and handles turnaround and PHY-initiated aborts.
// Every output is a register; status pulses follow the sampling edge.
module ulpi_link_ctrl #(
  parameter int MAX_TX_BYTES = 64,
  parameter int LEN_W        = $clog2(MAX_TX_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      ulpi_dir,
  input  logic                      ulpi_nxt,
  input  logic [7:0]                ulpi_data_in,
  output logic [7:0]                ulpi_data_out,
  output logic                      ulpi_stp,
  input  logic                      tx_start,
  input  logic [3:0]                tx_pid,
  input  logic [LEN_W-1:0]          tx_len,
  input  logic [8*MAX_TX_BYTES-1:0] tx_payload,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      tx_abort,
  output logic                      rx_byte_valid,
  output logic [7:0]                rx_byte,
  output logic                      rx_cmd_valid,
  output logic [7:0]                rx_cmd,
  output logic                      rx_active
);

  import ulpi_pkg::*;

  ulpi_state_t r_state;
  logic [7:0]  r_data_out;
  logic        r_stp;
  logic        r_tx_busy;
  logic        r_tx_done;
  logic        r_tx_abort;
  logic        r_rx_byte_valid;
  logic [7:0]  r_rx_byte;
  logic        r_rx_cmd_valid;
  logic [7:0]  r_rx_cmd;
  logic        r_rx_active;

  logic        w_load;
  logic        w_advance;
  logic [7:0]  w_cur_byte;
  logic [7:0]  w_next_byte;
  logic        w_last;
  logic        w_empty;

  // A request is taken only in IDLE with the bus ours; dir wins otherwise.
  assign w_load    = (r_state == ST_IDLE) && !ulpi_dir && tx_start;
  // Shift to the following byte when a non-final data byte is accepted.
  assign w_advance = (r_state == ST_TX_DATA) && !ulpi_dir && ulpi_nxt && !w_last;

  ulpi_tx_shifter #(
    .MAX_TX_BYTES (MAX_TX_BYTES),
    .LEN_W        (LEN_W)
  ) u_tx_shifter (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_load      (w_load),
    .i_len       (tx_len),
    .i_payload   (tx_payload),
    .i_advance   (w_advance),
    .o_cur_byte  (w_cur_byte),
    .o_next_byte (w_next_byte),
    .o_last      (w_last),
    .o_empty     (w_empty)
  );

  // Bus ownership FSM with registered bus drive, status pulses and RX capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= ST_IDLE;
      r_data_out      <= 8'h00;
      r_stp           <= 1'b0;
      r_tx_busy       <= 1'b0;
      r_tx_done       <= 1'b0;
      r_tx_abort      <= 1'b0;
      r_rx_byte_valid <= 1'b0;
      r_rx_byte       <= 8'h00;
      r_rx_cmd_valid  <= 1'b0;
      r_rx_cmd        <= 8'h00;
      r_rx_active     <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      r_stp           <= 1'b0;
      r_tx_done       <= 1'b0;
      r_tx_abort      <= 1'b0;
      r_rx_byte_valid <= 1'b0;
      r_rx_cmd_valid  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_data_out <= 8'h00;
          if (ulpi_dir) begin
            r_state <= ST_TURN_IN;
          end else if (tx_start) begin
            r_data_out <= txcmd_byte(tx_pid);
            r_tx_busy  <= 1'b1;
            r_state    <= ST_TX_CMD;
          end
        end

        ST_TX_CMD: begin
          if (ulpi_dir) begin
            r_data_out <= 8'h00;
            r_tx_abort <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_state    <= ST_TURN_IN;
          end else if (ulpi_nxt) begin
            if (w_empty) begin
              r_data_out <= 8'h00;
              r_stp      <= 1'b1;
              r_tx_done  <= 1'b1;
              r_tx_busy  <= 1'b0;
              r_state    <= ST_TX_STP;
            end else begin
              r_data_out <= w_cur_byte;
              r_state    <= ST_TX_DATA;
            end
          end
        end

        ST_TX_DATA: begin
          if (ulpi_dir) begin
            r_data_out <= 8'h00;
            r_tx_abort <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_state    <= ST_TURN_IN;
          end else if (ulpi_nxt) begin
            if (w_last) begin
              r_data_out <= 8'h00;
              r_stp      <= 1'b1;
              r_tx_done  <= 1'b1;
              r_tx_busy  <= 1'b0;
              r_state    <= ST_TX_STP;
            end else begin
              r_data_out <= w_next_byte;
            end
          end
        end

        ST_TX_STP: begin
          r_data_out <= 8'h00;
          r_state    <= ST_IDLE;
        end

        // Turnaround cycle: bus content is not valid yet.
        ST_TURN_IN: begin
          r_state <= ulpi_dir ? ST_RX : ST_TURN_OUT;
        end

        ST_RX: begin
          if (!ulpi_dir) begin
            r_state <= ST_TURN_OUT;
          end else if (ulpi_nxt) begin
            r_rx_byte       <= ulpi_data_in;
            r_rx_byte_valid <= 1'b1;
          end else begin
            r_rx_cmd       <= ulpi_data_in;
            r_rx_cmd_valid <= 1'b1;
            r_rx_active    <= rxcmd_is_active(ulpi_data_in);
          end
        end

        ST_TURN_OUT: begin
          r_rx_active <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_data_out <= 8'h00;
          r_tx_busy  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign ulpi_data_out = r_data_out;
  assign ulpi_stp      = r_stp;
  assign tx_busy       = r_tx_busy;
  assign tx_done       = r_tx_done;
  assign tx_abort      = r_tx_abort;
  assign rx_byte_valid = r_rx_byte_valid;
  assign rx_byte       = r_rx_byte;
  assign rx_cmd_valid  = r_rx_cmd_valid;
  assign rx_cmd        = r_rx_cmd;
  assign rx_active     = r_rx_active;

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// tb_ulpi_link_ctrl: vector table, directed corner sequences, and randomized
// TX/RX/abort traffic checked against a queue-based packet model.
module tb_ulpi_link_ctrl;

  localparam int MAX = 8;
  localparam int LW  = $clog2(MAX + 1);

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            ulpi_dir = 1'b0;
  logic            ulpi_nxt = 1'b0;
  logic [7:0]      ulpi_data_in = 8'h00;
  logic [7:0]      ulpi_data_out;
  logic            ulpi_stp;
  logic            tx_start = 1'b0;
  logic [3:0]      tx_pid = 4'h0;
  logic [LW-1:0]   tx_len = '0;
  logic [8*MAX-1:0] tx_payload = '0;
  logic            tx_busy, tx_done, tx_abort;
  logic            rx_byte_valid, rx_cmd_valid, rx_active;
  logic [7:0]      rx_byte, rx_cmd;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the held RX registers.
  logic [7:0] m_cmd  = 8'h00;
  logic [7:0] m_byte = 8'h00;
  logic       m_act  = 1'b0;

  typedef struct {
    logic          dir;
    logic          nxt;
    logic          start;
    logic [7:0]    din;
    logic [3:0]    pid;
    logic [LW-1:0] len;
    logic [30:0]   exp;
  } vec_t;

  vec_t tbl [32];

  ulpi_link_ctrl #(.MAX_TX_BYTES(MAX)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .ulpi_dir      (ulpi_dir),
    .ulpi_nxt      (ulpi_nxt),
    .ulpi_data_in  (ulpi_data_in),
    .ulpi_data_out (ulpi_data_out),
    .ulpi_stp      (ulpi_stp),
    .tx_start      (tx_start),
    .tx_pid        (tx_pid),
    .tx_len        (tx_len),
    .tx_payload    (tx_payload),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_abort      (tx_abort),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .rx_cmd_valid  (rx_cmd_valid),
    .rx_cmd        (rx_cmd),
    .rx_active     (rx_active)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] pack(input logic [7:0] dout, input logic stp, input logic busy,
                                       input logic done, input logic ab, input logic cv,
                                       input logic [7:0] cmd, input logic bv,
                                       input logic [7:0] byt, input logic act);
    return {dout, stp, busy, done, ab, cv, cmd, bv, byt, act};
  endfunction

  function automatic logic [30:0] dut_outs();
    return {ulpi_data_out, ulpi_stp, tx_busy, tx_done, tx_abort, rx_cmd_valid, rx_cmd,
            rx_byte_valid, rx_byte, rx_active};
  endfunction

  function automatic vec_t mk(input int d, input int n, input int s, input int din, input int pid,
                              input int len, input int dout, input int stp, input int busy,
                              input int done, input int ab, input int cv, input int cmd,
                              input int bv, input int byt, input int act);
    vec_t v;
    v.dir   = 1'(d);
    v.nxt   = 1'(n);
    v.start = 1'(s);
    v.din   = 8'(din);
    v.pid   = 4'(pid);
    v.len   = LW'(len);
    v.exp   = pack(8'(dout), 1'(stp), 1'(busy), 1'(done), 1'(ab), 1'(cv), 8'(cmd), 1'(bv),
                   8'(byt), 1'(act));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [30:0] act, input logic [30:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut {dout,stp,busy,done,abort,cv,cmd,bv,byte,act}=%h expected %h",
               nm, act, exp);
    end
  endtask

  // Spec rule: RxActive is RxEvent (bits 5:4) equal to 1.
  function automatic logic rx_act_of(input logic [7:0] b);
    return ((b >> 4) & 8'h03) == 8'h01;
  endfunction

  // From TURN_IN (dir held high): one turnaround, n RX bytes, then dir drop.
  task automatic rx_burst(input int n, input string tag);
    logic [7:0] b;
    logic       nx;
    ulpi_dir     = 1'b1;
    ulpi_nxt     = 1'($urandom_range(0, 1));
    ulpi_data_in = 8'($urandom);
    @(negedge clk);
    chk({tag, "_turn"}, dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, m_act));
    for (int k = 0; k < n; k++) begin
      b  = 8'($urandom);
      nx = 1'($urandom_range(0, 1));
      ulpi_nxt     = nx;
      ulpi_data_in = b;
      @(negedge clk);
      if (nx) m_byte = b;
      else begin
        m_cmd = b;
        m_act = rx_act_of(b);
      end
      chk($sformatf("%s_rx%0d", tag, k), dut_outs(),
          pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, !nx, m_cmd, nx, m_byte, m_act));
    end
    ulpi_dir     = 1'b0;
    ulpi_nxt     = 1'($urandom_range(0, 1));
    ulpi_data_in = 8'($urandom);
    @(negedge clk);
    chk({tag, "_tout"}, dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, m_act));
    ulpi_nxt = 1'b0;
    @(negedge clk);
    m_act = 1'b0;
    chk({tag, "_idle"}, dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, m_act));
  endtask

  // Random packet: expected bus bytes kept as a queue, popped on each nxt.
  task automatic rand_tx(input int it);
    int         len, nb, cyc, ab_at;
    bit         do_ab;
    logic [3:0] pid;
    logic [7:0] q[$];
    string      tag;
    tag = $sformatf("rtx%0d", it);
    pid = 4'($urandom_range(0, 15));
    len = $urandom_range(0, 15);
    for (int i = 0; i < MAX; i++) tx_payload[i*8 +: 8] = 8'($urandom);
    nb = (len > MAX) ? MAX : len;
    q.push_back(8'h40 | {4'h0, pid});
    for (int i = 0; i < nb; i++) q.push_back(tx_payload[i*8 +: 8]);
    do_ab = ($urandom_range(0, 3) == 0);
    ab_at = $urandom_range(0, 2 * nb + 2);
    ulpi_dir = 1'b0;
    ulpi_nxt = 1'b0;
    tx_pid   = pid;
    tx_len   = LW'(len);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    cyc = 0;
    while (q.size() > 0) begin
      chk($sformatf("%s_c%0d", tag, cyc), dut_outs(),
          pack(q[0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, 1'b0));
      if (do_ab && cyc == ab_at) begin
        ulpi_dir = 1'b1;
        ulpi_nxt = 1'($urandom_range(0, 1));
        tx_start = 1'b0;
        @(negedge clk);
        chk({tag, "_abort"}, dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_cmd, 1'b0, m_byte, 1'b0));
        rx_burst($urandom_range(0, 4), tag);
        return;
      end
      ulpi_nxt = 1'($urandom_range(0, 1));
      tx_start = ($urandom_range(0, 3) == 0);
      tx_pid   = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (ulpi_nxt) void'(q.pop_front());
      cyc++;
      if (cyc > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_budget: %0d bytes still pending, required 0", tag, q.size());
        break;
      end
    end
    tx_start = 1'b0;
    ulpi_nxt = 1'b0;
    chk({tag, "_stp"}, dut_outs(), pack(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, 1'b0));
    @(negedge clk);
    chk({tag, "_end"}, dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, 1'b0));
  endtask

  task automatic rand_rx(input int it);
    string tag;
    tag = $sformatf("rrx%0d", it);
    ulpi_dir     = 1'b1;
    ulpi_nxt     = 1'($urandom_range(0, 1));
    ulpi_data_in = 8'($urandom);
    tx_start     = 1'($urandom_range(0, 1));
    tx_pid       = 4'($urandom_range(0, 15));
    tx_len       = LW'($urandom_range(0, 15));
    @(negedge clk);
    tx_start = 1'b0;
    chk({tag, "_in"}, dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cmd, 1'b0, m_byte, m_act));
    rx_burst($urandom_range(0, 6), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // Cycle vectors from reset: RX CMD, RX burst, 3-byte TX, PID-only TX,
    // dir beating tx_start in IDLE.
    tbl[0]  = mk(1,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h00,0,'h00,0);
    tbl[1]  = mk(1,0,0,'h5A,0,0, 'h00,0,0,0,0, 0,'h00,0,'h00,0);
    tbl[2]  = mk(1,0,0,'h1F,0,0, 'h00,0,0,0,0, 1,'h1F,0,'h00,1);
    tbl[3]  = mk(0,0,0,'h77,0,0, 'h00,0,0,0,0, 0,'h1F,0,'h00,1);
    tbl[4]  = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h1F,0,'h00,0);
    tbl[5]  = mk(1,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h1F,0,'h00,0);
    tbl[6]  = mk(1,1,0,'h33,0,0, 'h00,0,0,0,0, 0,'h1F,0,'h00,0);
    tbl[7]  = mk(1,0,0,'h10,0,0, 'h00,0,0,0,0, 1,'h10,0,'h00,1);
    tbl[8]  = mk(1,1,0,'hAA,0,0, 'h00,0,0,0,0, 0,'h10,1,'hAA,1);
    tbl[9]  = mk(1,1,0,'h55,0,0, 'h00,0,0,0,0, 0,'h10,1,'h55,1);
    tbl[10] = mk(1,1,0,'hFF,0,0, 'h00,0,0,0,0, 0,'h10,1,'hFF,1);
    tbl[11] = mk(0,1,0,'h12,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,1);
    tbl[12] = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);
    tbl[13] = mk(0,0,1,'h00,3,3, 'h43,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[14] = mk(0,0,1,'h00,15,5,'h43,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[15] = mk(0,0,0,'h00,0,0, 'h43,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[16] = mk(0,1,0,'h00,0,0, 'hBB,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[17] = mk(0,0,0,'h00,0,0, 'hBB,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[18] = mk(0,1,0,'h00,0,0, 'hAA,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[19] = mk(0,0,0,'h00,0,0, 'hAA,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[20] = mk(0,1,0,'h00,0,0, 'hCC,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[21] = mk(0,0,0,'h00,0,0, 'hCC,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[22] = mk(0,1,0,'h00,0,0, 'h00,1,0,1,0, 0,'h10,0,'hFF,0);
    tbl[23] = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);
    tbl[24] = mk(0,0,1,'h00,2,0, 'h42,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[25] = mk(0,0,0,'h00,0,0, 'h42,0,1,0,0, 0,'h10,0,'hFF,0);
    tbl[26] = mk(0,1,0,'h00,0,0, 'h00,1,0,1,0, 0,'h10,0,'hFF,0);
    tbl[27] = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);
    tbl[28] = mk(1,0,1,'h00,5,1, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);
    tbl[29] = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);
    tbl[30] = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);
    tbl[31] = mk(0,0,0,'h00,0,0, 'h00,0,0,0,0, 0,'h10,0,'hFF,0);

    tx_payload = '0;
    tx_payload[7:0]   = 8'hBB;
    tx_payload[15:8]  = 8'hAA;
    tx_payload[23:16] = 8'hCC;
    tx_payload[31:24] = 8'hDD;

    n_rst = 1'b0;
    @(negedge clk);
    chk("reset_state", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    n_rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      ulpi_dir     = tbl[i].dir;
      ulpi_nxt     = tbl[i].nxt;
      ulpi_data_in = tbl[i].din;
      tx_start     = tbl[i].start;
      tx_pid       = tbl[i].pid;
      tx_len       = tbl[i].len;
      @(negedge clk);
      chk($sformatf("vec[%0d]", i), dut_outs(), tbl[i].exp);
    end
    tx_start = 1'b0;

    // Abort while byte 1 of 4 is pending, then RX CMD 0x10 after turnaround.
    tx_pid = 4'h1; tx_len = LW'(4); tx_start = 1'b1; ulpi_nxt = 1'b0; ulpi_dir = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    chk("ab_cmd", dut_outs(), pack(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));
    ulpi_nxt = 1'b1;
    @(negedge clk);
    chk("ab_b0", dut_outs(), pack(8'hBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));
    @(negedge clk);
    chk("ab_b1", dut_outs(), pack(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));
    ulpi_dir = 1'b1; ulpi_nxt = 1'b0;
    @(negedge clk);
    chk("ab_abort", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));
    ulpi_data_in = 8'hE7;
    @(negedge clk);
    chk("ab_turn", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));
    ulpi_data_in = 8'h10;
    @(negedge clk);
    chk("ab_rxcmd", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'hFF, 1'b1));
    ulpi_dir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ab_idle", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));

    // Reset in the middle of a packet: everything clears, no stp follows.
    tx_pid = 4'h6; tx_len = LW'(4); tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; ulpi_nxt = 1'b1;
    @(negedge clk);
    chk("rst_pre", dut_outs(), pack(8'hBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'hFF, 1'b0));
    #2 n_rst = 1'b0;
    #1;
    chk("rst_async", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    chk("rst_hold", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    n_rst = 1'b1; ulpi_nxt = 1'b1;
    @(negedge clk);
    ulpi_nxt = 1'b0;
    chk("rst_after", dut_outs(), pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
    m_cmd = 8'h00; m_byte = 8'h00; m_act = 1'b0;

    // Randomized traffic against the packet model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) rand_tx(it);
      else rand_rx(it);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
